// File: rtl/mu0_pkg.sv
// MU0 shared definitions: arbiter state and owner encodings, default bus widths,
// and the opcode constants used by the core controller.
package mu0_pkg;

  localparam int MU0_AW = 12;
  localparam int MU0_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  // A zero-wait configuration still needs a one-bit counter.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mu0_mem_arbiter_if.sv
// Bundle of requester (CPU, DMA) and memory-side signals around the MU0 memory arbiter.
// master = requesters plus memory model, slave = the arbiter.
interface mu0_mem_arbiter_if
  import mu0_pkg::*;
#(
  parameter int AW = MU0_AW,
  parameter int DW = MU0_DW
);

  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;

  logic          dma_req;
  logic          dma_rnw;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_wait,
    input  dma_req, dma_rnw, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_wait,
    output dma_req, dma_rnw, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );

endinterface

// File: rtl/mu0_rr_pick.sv
// Two-way round-robin chooser: a lone requester wins; on a tie the requester
// that did not own the previous access wins.
module mu0_rr_pick
  import mu0_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_owner_i,
  output owner_e     grant_o,
  output logic       valid_o
);

  // req_i[0] is the CPU, req_i[1] the DMA port.
  always_comb begin
    grant_o = OWN_CPU;
    valid_o = 1'b0;
    case (req_i)
      2'b01: begin
        grant_o = OWN_CPU;
        valid_o = 1'b1;
      end
      2'b10: begin
        grant_o = OWN_DMA;
        valid_o = 1'b1;
      end
      2'b11: begin
        valid_o = 1'b1;
        if (last_owner_i == OWN_CPU) begin
          grant_o = OWN_DMA;
        end else begin
          grant_o = OWN_CPU;
        end
      end
      default: begin
        grant_o = OWN_CPU;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Shares the single MU0 memory between the core and a DMA/loader port: round-robin
// grant, latched access held for WAIT_CYCLES+1 cycles, registered rdata and one-cycle ack.
module mu0_mem_arbiter
  import mu0_pkg::*;
#(
  parameter int AW          = MU0_AW,
  parameter int DW          = MU0_DW,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  mu0_mem_arbiter_if.slave bus
);

  localparam int            CW       = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_e        owner_q, owner_d;
  owner_e        last_owner_q, last_owner_d;
  logic          rnw_q, rnw_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;

  owner_e        pick_grant_s;
  logic          pick_valid_s;

  mu0_rr_pick u_pick (
    .req_i        ({bus.dma_req, bus.cpu_req}),
    .last_owner_i (last_owner_q),
    .grant_o      (pick_grant_s),
    .valid_o      (pick_valid_s)
  );

  // State and output registers; a reset mid-access drops mem_cs/mem_we at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      rnw_q        <= 1'b1;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rnw_q        <= rnw_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

  // Next-state and next-output logic; acks default low so they pulse for one cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rnw_d        = rnw_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          owner_d      = pick_grant_s;
          last_owner_d = pick_grant_s;
          mem_cs_d     = 1'b1;
          cnt_d        = CNT_INIT;
          state_d      = ST_ACCESS;
          if (pick_grant_s == OWN_DMA) begin
            rnw_d       = bus.dma_rnw;
            mem_we_d    = ~bus.dma_rnw;
            mem_addr_d  = bus.dma_addr;
            mem_wdata_d = bus.dma_wdata;
          end else begin
            rnw_d       = bus.cpu_rnw;
            mem_we_d    = ~bus.cpu_rnw;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
          end
        end else begin
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // mem_rdata is valid in this last select cycle.
          if (rnw_q && (owner_q == OWN_DMA)) begin
            dma_rdata_d = bus.mem_rdata;
          end else if (rnw_q) begin
            cpu_rdata_d = bus.mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          if (owner_q == OWN_DMA) begin
            dma_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = CNT_ZERO;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.owner     = owner_q;
  assign bus.cpu_wait  = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Self-checking bench for mu0_mem_arbiter: directed scenarios on WAIT_CYCLES=1 and 0
// instances, then randomized traffic against a transaction-level reference model.
module tb_mu0_mem_arbiter;
  import mu0_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int WAIT1 = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mu0_mem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  mu0_mem_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

  mu0_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  mu0_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Memory environment: unwritten locations return a fixed pattern.
  bit [15:0]   env_mem1 [4096];
  bit          env_wr1  [4096];
  logic [15:0] ref_mem  [4096];

  function automatic logic [15:0] mem_init(input logic [11:0] a);
    if (a == 12'h012) return 16'hBEEF;
    return {a[3:0], a} ^ 16'h5A5A;
  endfunction

  assign bus1.mem_rdata = env_wr1[bus1.mem_addr] ? env_mem1[bus1.mem_addr] : mem_init(bus1.mem_addr);
  assign bus0.mem_rdata = mem_init(bus0.mem_addr);

  always @(posedge clk) begin
    if (bus1.mem_cs && bus1.mem_we) begin
      env_mem1[bus1.mem_addr] <= bus1.mem_wdata;
      env_wr1[bus1.mem_addr]  <= 1'b1;
    end
  end

  task automatic idle_inputs();
    bus1.cpu_req = 1'b0; bus1.cpu_rnw = 1'b1; bus1.cpu_addr = 12'h000; bus1.cpu_wdata = 16'h0000;
    bus1.dma_req = 1'b0; bus1.dma_rnw = 1'b1; bus1.dma_addr = 12'h000; bus1.dma_wdata = 16'h0000;
    bus0.cpu_req = 1'b0; bus0.cpu_rnw = 1'b1; bus0.cpu_addr = 12'h000; bus0.cpu_wdata = 16'h0000;
    bus0.dma_req = 1'b0; bus0.dma_rnw = 1'b1; bus0.dma_addr = 12'h000; bus0.dma_wdata = 16'h0000;
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b0;
    bus1.cpu_req = 1'b1; bus1.cpu_rnw = 1'b1; bus1.cpu_addr = 12'h100;
    bus1.dma_req = 1'b1; bus1.dma_rnw = 1'b1; bus1.dma_addr = 12'h200;
    repeat (2) @(negedge clk);
    n_checks++; if (bus1.mem_cs !== 1'b0) begin n_fail++; $display("FAIL reset_mem_cs: got %b want 0", bus1.mem_cs); end
    n_checks++; if (bus1.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus1.mem_we); end
    n_checks++; if ({bus1.cpu_ack, bus1.dma_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {bus1.cpu_ack, bus1.dma_ack}); end
    n_checks++; if (bus1.cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h want 0000", bus1.cpu_rdata); end
    n_checks++; if (bus1.dma_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_dma_rdata: got %h want 0000", bus1.dma_rdata); end
    n_checks++; if (bus1.mem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 000", bus1.mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus1.owner !== 1'b0) begin n_fail++; $display("FAIL reset_first_owner: got %b want 0 (CPU)", bus1.owner); end
    n_checks++; if (bus1.mem_cs !== 1'b1 || bus1.mem_addr !== 12'h100) begin n_fail++; $display("FAIL reset_first_grant: cs=%b addr=%h want cs=1 addr=100", bus1.mem_cs, bus1.mem_addr); end
    bus1.cpu_req = 1'b0; bus1.dma_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_first_ack: cpu_ack not seen in 6 cycles, want a pulse"); end
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    bit exp_cs, exp_ack;
    bus1.cpu_req = 1'b1; bus1.cpu_rnw = 1'b1; bus1.cpu_addr = 12'h012;
    #1;
    n_checks++; if (bus1.cpu_wait !== 1'b1 || bus1.mem_cs !== 1'b0) begin n_fail++; $display("FAIL rd_cycle0: wait=%b cs=%b want wait=1 cs=0", bus1.cpu_wait, bus1.mem_cs); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp_cs  = (c <= 2);
      exp_ack = (c == 3);
      n_checks++; if (bus1.mem_cs !== exp_cs) begin n_fail++; $display("FAIL rd_cs_c%0d: got %b want %b", c, bus1.mem_cs, exp_cs); end
      n_checks++; if (bus1.cpu_ack !== exp_ack || bus1.dma_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_c%0d: cpu=%b dma=%b want cpu=%b dma=0", c, bus1.cpu_ack, bus1.dma_ack, exp_ack); end
      n_checks++; if (bus1.cpu_wait !== !exp_ack) begin n_fail++; $display("FAIL rd_wait_c%0d: got %b want %b", c, bus1.cpu_wait, !exp_ack); end
      if (c <= 2) begin
        n_checks++; if (bus1.mem_addr !== 12'h012 || bus1.mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_addr_c%0d: addr=%h we=%b want 012/0", c, bus1.mem_addr, bus1.mem_we); end
      end
    end
    n_checks++; if (bus1.cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want beef", bus1.cpu_rdata); end
    bus1.cpu_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus1.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_width: got %b want 0", bus1.cpu_ack); end
  endtask

  task automatic test_dma_write();
    bus1.dma_req = 1'b1; bus1.dma_rnw = 1'b0; bus1.dma_addr = 12'h034; bus1.dma_wdata = 16'h1234;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus1.mem_cs !== 1'b1 || bus1.mem_we !== 1'b1 || bus1.mem_addr !== 12'h034 || bus1.mem_wdata !== 16'h1234 || bus1.owner !== 1'b1) begin
        n_fail++; $display("FAIL wr_bus_c%0d: cs=%b we=%b addr=%h wd=%h own=%b want 1/1/034/1234/1", c, bus1.mem_cs, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.owner);
      end
    end
    @(negedge clk);
    n_checks++; if (bus1.dma_ack !== 1'b1 || bus1.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack: dma=%b cpu=%b want 1/0", bus1.dma_ack, bus1.cpu_ack); end
    n_checks++; if (bus1.mem_cs !== 1'b0 || bus1.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_release: cs=%b we=%b want 0/0", bus1.mem_cs, bus1.mem_we); end
    n_checks++; if (bus1.dma_rdata !== 16'h0000 || bus1.cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rdata_kept: dma=%h cpu=%h want 0000/beef", bus1.dma_rdata, bus1.cpu_rdata); end
    ref_mem[12'h034] = 16'h1234;
    bus1.dma_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus1.dma_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_width: got %b want 0", bus1.dma_ack); end
  endtask

  task automatic test_round_robin();
    owner_e exp_own;
    bit     seen;
    int     cyc;
    exp_own = OWN_CPU;
    bus1.cpu_req = 1'b1; bus1.cpu_rnw = 1'b1; bus1.cpu_addr = 12'h012;
    bus1.dma_req = 1'b1; bus1.dma_rnw = 1'b1; bus1.dma_addr = 12'h034;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0; cyc = 0;
      for (int i = 1; i <= 8 && !seen; i++) begin
        @(negedge clk);
        if (bus1.cpu_ack === 1'b1 || bus1.dma_ack === 1'b1) begin seen = 1'b1; cyc = i; end
      end
      n_checks++; if (!seen || cyc != WAIT1 + 2) begin n_fail++; $display("FAIL rr_latency_%0d: ack at cycle %0d want %0d", k, cyc, WAIT1 + 2); end
      n_checks++; if (bus1.owner !== exp_own) begin n_fail++; $display("FAIL rr_owner_%0d: got %b want %b", k, bus1.owner, exp_own); end
      n_checks++; if (bus1.cpu_ack !== (exp_own == OWN_CPU) || bus1.dma_ack !== (exp_own == OWN_DMA)) begin n_fail++; $display("FAIL rr_ack_%0d: cpu=%b dma=%b owner want %b", k, bus1.cpu_ack, bus1.dma_ack, exp_own); end
      n_checks++;
      if ((exp_own == OWN_CPU) ? (bus1.cpu_rdata !== ref_mem[12'h012]) : (bus1.dma_rdata !== ref_mem[12'h034])) begin
        n_fail++; $display("FAIL rr_rdata_%0d: cpu=%h dma=%h want cpu=%h or dma=%h", k, bus1.cpu_rdata, bus1.dma_rdata, ref_mem[12'h012], ref_mem[12'h034]);
      end
      if (k == 3) begin bus1.cpu_req = 1'b0; bus1.dma_req = 1'b0; end
      @(negedge clk);
      n_checks++; if (bus1.cpu_ack !== 1'b0 || bus1.dma_ack !== 1'b0) begin n_fail++; $display("FAIL rr_ack_width_%0d: cpu=%b dma=%b want 0/0", k, bus1.cpu_ack, bus1.dma_ack); end
      exp_own = (exp_own == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end
  endtask

  task automatic test_latch_drop();
    bus1.cpu_req = 1'b1; bus1.cpu_rnw = 1'b1; bus1.cpu_addr = 12'h012;
    @(negedge clk);
    n_checks++; if (bus1.mem_addr !== 12'h012) begin n_fail++; $display("FAIL drop_addr_c1: got %h want 012", bus1.mem_addr); end
    bus1.cpu_addr = 12'h0FF; bus1.cpu_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus1.mem_addr !== 12'h012 || bus1.mem_cs !== 1'b1) begin n_fail++; $display("FAIL drop_addr_c2: addr=%h cs=%b want 012/1", bus1.mem_addr, bus1.mem_cs); end
    n_checks++; if (bus1.cpu_wait !== 1'b0) begin n_fail++; $display("FAIL drop_wait: got %b want 0", bus1.cpu_wait); end
    @(negedge clk);
    n_checks++; if (bus1.cpu_ack !== 1'b1 || bus1.cpu_rdata !== ref_mem[12'h012]) begin n_fail++; $display("FAIL drop_ack: ack=%b rdata=%h want 1/%h", bus1.cpu_ack, bus1.cpu_rdata, ref_mem[12'h012]); end
    @(negedge clk);
    n_checks++; if (bus1.cpu_ack !== 1'b0 || bus1.mem_cs !== 1'b0) begin n_fail++; $display("FAIL drop_idle: ack=%b cs=%b want 0/0", bus1.cpu_ack, bus1.mem_cs); end
  endtask

  task automatic test_reset_mid_access();
    int  acks;
    bit  seen;
    bus1.dma_req = 1'b1; bus1.dma_rnw = 1'b0; bus1.dma_addr = 12'h3C0; bus1.dma_wdata = 16'hCAFE;
    @(negedge clk);
    n_checks++; if (bus1.mem_cs !== 1'b1 || bus1.mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: cs=%b we=%b want 1/1", bus1.mem_cs, bus1.mem_we); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus1.mem_cs !== 1'b0 || bus1.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: cs=%b we=%b want 0/0", bus1.mem_cs, bus1.mem_we); end
    n_checks++; if (bus1.dma_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0000", bus1.dma_rdata); end
    bus1.dma_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus1.cpu_ack === 1'b1 || bus1.dma_ack === 1'b1 || bus1.mem_cs === 1'b1) acks++;
    end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rst_mid_no_ack: %0d cycles with ack/cs want 0", acks); end
    bus1.cpu_req = 1'b1; bus1.cpu_rnw = 1'b1; bus1.cpu_addr = 12'h012;
    bus1.dma_req = 1'b1; bus1.dma_rnw = 1'b1; bus1.dma_addr = 12'h034;
    @(negedge clk);
    n_checks++; if (bus1.owner !== 1'b0 || bus1.mem_cs !== 1'b1) begin n_fail++; $display("FAIL rst_mid_regrant: owner=%b cs=%b want 0/1", bus1.owner, bus1.mem_cs); end
    bus1.cpu_req = 1'b0; bus1.dma_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_mid_regrant_ack: cpu_ack not seen, want a pulse"); end
    @(negedge clk);
  endtask

  task automatic test_wait0();
    bus0.cpu_req = 1'b1; bus0.cpu_rnw = 1'b1; bus0.cpu_addr = 12'h012;
    #1;
    n_checks++; if (bus0.cpu_wait !== 1'b1) begin n_fail++; $display("FAIL w0_wait: got %b want 1", bus0.cpu_wait); end
    @(negedge clk);
    n_checks++; if (bus0.mem_cs !== 1'b1 || bus0.cpu_ack !== 1'b0 || bus0.mem_addr !== 12'h012) begin n_fail++; $display("FAIL w0_rd_c1: cs=%b ack=%b addr=%h want 1/0/012", bus0.mem_cs, bus0.cpu_ack, bus0.mem_addr); end
    @(negedge clk);
    n_checks++; if (bus0.cpu_ack !== 1'b1 || bus0.mem_cs !== 1'b0 || bus0.cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL w0_rd_c2: ack=%b cs=%b rdata=%h want 1/0/beef", bus0.cpu_ack, bus0.mem_cs, bus0.cpu_rdata); end
    bus0.cpu_req = 1'b0;
    @(negedge clk);
    bus0.dma_req = 1'b1; bus0.dma_rnw = 1'b0; bus0.dma_addr = 12'h055; bus0.dma_wdata = 16'hA5A5;
    @(negedge clk);
    n_checks++; if (bus0.mem_cs !== 1'b1 || bus0.mem_we !== 1'b1 || bus0.mem_wdata !== 16'hA5A5 || bus0.owner !== 1'b1) begin n_fail++; $display("FAIL w0_wr_c1: cs=%b we=%b wd=%h own=%b want 1/1/a5a5/1", bus0.mem_cs, bus0.mem_we, bus0.mem_wdata, bus0.owner); end
    @(negedge clk);
    n_checks++; if (bus0.dma_ack !== 1'b1 || bus0.dma_rdata !== 16'h0000 || bus0.cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL w0_wr_c2: ack=%b dma=%h cpu=%h want 1/0000/beef", bus0.dma_ack, bus0.dma_rdata, bus0.cpu_rdata); end
    bus0.dma_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    owner_e      last, win;
    bit          p_cpu, p_dma;
    logic [15:0] ref_cpu, ref_dma;
    logic [11:0] w_addr;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    last = OWN_DMA; p_cpu = 1'b0; p_dma = 1'b0;
    ref_cpu = 16'h0000; ref_dma = 16'h0000;
    for (int it = 0; it < 80; it++) begin
      if (!p_cpu && ($urandom_range(0, 1) == 1)) begin
        p_cpu = 1'b1; bus1.cpu_req = 1'b1; bus1.cpu_rnw = 1'($urandom_range(0, 1));
        bus1.cpu_addr = 12'($urandom_range(0, 15)); bus1.cpu_wdata = 16'($urandom);
      end
      if (!p_dma && ($urandom_range(0, 1) == 1)) begin
        p_dma = 1'b1; bus1.dma_req = 1'b1; bus1.dma_rnw = 1'($urandom_range(0, 1));
        bus1.dma_addr = 12'($urandom_range(0, 15)); bus1.dma_wdata = 16'($urandom);
      end
      if (!p_cpu && !p_dma) begin
        @(negedge clk);
        continue;
      end
      if (p_cpu && p_dma) win = (last == OWN_CPU) ? OWN_DMA : OWN_CPU;
      else win = p_cpu ? OWN_CPU : OWN_DMA;
      last = win;
      if (win == OWN_CPU) begin
        w_addr = bus1.cpu_addr;
        if (bus1.cpu_rnw) ref_cpu = ref_mem[w_addr]; else ref_mem[w_addr] = bus1.cpu_wdata;
      end else begin
        w_addr = bus1.dma_addr;
        if (bus1.dma_rnw) ref_dma = ref_mem[w_addr]; else ref_mem[w_addr] = bus1.dma_wdata;
      end
      for (int c = 1; c <= WAIT1 + 2; c++) begin
        @(negedge clk);
        if (c <= WAIT1 + 1) begin
          n_checks++;
          if (bus1.mem_cs !== 1'b1 || bus1.owner !== win || bus1.mem_addr !== w_addr || bus1.cpu_ack !== 1'b0 || bus1.dma_ack !== 1'b0) begin
            n_fail++; $display("FAIL rnd_access_%0d_c%0d: cs=%b own=%b addr=%h acks=%b%b want 1/%b/%h/00", it, c, bus1.mem_cs, bus1.owner, bus1.mem_addr, bus1.cpu_ack, bus1.dma_ack, win, w_addr);
          end
        end else begin
          n_checks++;
          if (bus1.cpu_ack !== (win == OWN_CPU) || bus1.dma_ack !== (win == OWN_DMA) || bus1.mem_cs !== 1'b0) begin
            n_fail++; $display("FAIL rnd_ack_%0d: acks=%b%b cs=%b want winner %b, cs 0", it, bus1.cpu_ack, bus1.dma_ack, bus1.mem_cs, win);
          end
          n_checks++;
          if (bus1.cpu_rdata !== ref_cpu || bus1.dma_rdata !== ref_dma) begin
            n_fail++; $display("FAIL rnd_rdata_%0d: cpu=%h dma=%h want cpu=%h dma=%h", it, bus1.cpu_rdata, bus1.dma_rdata, ref_cpu, ref_dma);
          end
        end
      end
      if (win == OWN_CPU) begin p_cpu = 1'b0; bus1.cpu_req = 1'b0; end
      else begin p_dma = 1'b0; bus1.dma_req = 1'b0; end
      @(negedge clk);
      n_checks++; if (bus1.cpu_ack !== 1'b0 || bus1.dma_ack !== 1'b0) begin n_fail++; $display("FAIL rnd_ack_width_%0d: acks=%b%b want 00", it, bus1.cpu_ack, bus1.dma_ack); end
    end
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    for (int a = 0; a < 4096; a++) ref_mem[a] = mem_init(12'(a));
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_round_robin();
    test_latch_drop();
    test_reset_mid_access();
    test_wait0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
